// File: rtl/scr1_axi_pkg.sv
// Shared AXI definitions for the SCR1 memory slave: response codes, FSM
// state encodings and the request legality check.
package scr1_axi_pkg;

    localparam logic [1:0] SCR1_AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] SCR1_AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'b00,
        W_WAIT_DATA = 2'b01,
        W_WAIT_ADDR = 2'b10,
        W_RESP      = 2'b11
    } type_scr1_axi_wr_fsm_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } type_scr1_axi_rd_fsm_e;

    // Legal when inside the array window, size is at most a word and the
    // address is naturally aligned to that size.
    function automatic logic scr1_axi_req_legal(
        input logic       in_range,
        input logic [1:0] addr_lo,
        input logic [2:0] size
    );
        logic aligned;
        case (size)
            3'b000:  aligned = 1'b1;
            3'b001:  aligned = ~addr_lo[0];
            3'b010:  aligned = (addr_lo == 2'b00);
            default: aligned = 1'b0;
        endcase
        return in_range & aligned;
    endfunction

endpackage

// File: rtl/scr1_axi_mem_array.sv
// Word-organised storage with one byte-enabled write port and one read port
// that captures a word (or zero) into an output register on demand.
module scr1_axi_mem_array
    import scr1_axi_pkg::*;
#(
    parameter int WORDS = 16384,
    parameter int IW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic          rzero,
    input  logic [IW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Storage is deliberately not reset; only strobed lanes are written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // A same-cycle write to the sampled word is not visible here: the
    // capture sees the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0000_0000;
        end else if (re) begin
            rdata <= rzero ? 32'h0000_0000 : mem[ridx];
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/scr1_axi_mem_slave.sv
// Single-port AXI4 slave memory: independent read and write FSMs over a
// byte-addressable 32-bit array, programmable read latency, SLVERR on
// illegal or burst requests.
module scr1_axi_mem_slave
    import scr1_axi_pkg::*;
#(
    parameter int                          SCR1_AXI_IDWIDTH = 4,
    parameter int                          SCR1_ADDR_WIDTH  = 32,
    parameter logic [SCR1_ADDR_WIDTH-1:0]  MEM_BASE         = 32'h0000_0000,
    parameter int                          MEM_SIZE         = 65536,
    parameter int                          READ_LATENCY     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SCR1_AXI_IDWIDTH-1:0]  awid,
    input  logic [SCR1_ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [SCR1_AXI_IDWIDTH-1:0]  bid,
    output logic [1:0]                   bresp,
    output logic [3:0]                   buser,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [SCR1_AXI_IDWIDTH-1:0]  arid,
    input  logic [SCR1_ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [SCR1_AXI_IDWIDTH-1:0]  rid,
    output logic [31:0]                  rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic [3:0]                   ruser,
    output logic                         rvalid,
    input  logic                         rready
);

    localparam int AW    = SCR1_ADDR_WIDTH;
    localparam int IDW   = SCR1_AXI_IDWIDTH;
    localparam int WORDS = MEM_SIZE / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW-1:0] MEM_SIZE_A = AW'(MEM_SIZE);
    localparam logic [3:0]    LAT_INIT   = 4'(READ_LATENCY - 1);

    // Address decode and legality of the incoming requests
    logic [AW-1:0] aw_off;
    logic [AW-1:0] ar_off;
    logic          aw_legal;
    logic          ar_legal;

    assign aw_off   = awaddr - MEM_BASE;
    assign ar_off   = araddr - MEM_BASE;
    assign aw_legal = scr1_axi_req_legal(aw_off < MEM_SIZE_A, awaddr[1:0], awsize)
                      & (awlen == 8'h00);
    assign ar_legal = scr1_axi_req_legal(ar_off < MEM_SIZE_A, araddr[1:0], arsize)
                      & (arlen == 8'h00);

    // ---------------- write channel ----------------
    type_scr1_axi_wr_fsm_e wr_state;
    type_scr1_axi_wr_fsm_e wr_next;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_ok_r;
    logic [IW-1:0]         aw_idx_r;
    logic [IDW-1:0]        bid_r;
    logic [31:0]           w_data_r;
    logic [3:0]            w_strb_r;
    logic                  wlast_seen_r;
    logic [1:0]            bresp_r;
    logic                  wr_commit;
    logic                  cur_ok;
    logic [IW-1:0]         cur_idx;
    logic [31:0]           cur_data;
    logic [3:0]            cur_strb;

    assign awready = ~rst & ((wr_state == W_IDLE) | (wr_state == W_WAIT_ADDR));
    assign wready  = ~rst & ((wr_state == W_IDLE) | (wr_state == W_WAIT_DATA));
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    // Write FSM next state; a W-first burst resumes data in W_WAIT_DATA
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs & w_hs) begin
                    wr_next = wlast ? W_RESP : W_WAIT_DATA;
                end else if (aw_hs) begin
                    wr_next = W_WAIT_DATA;
                end else if (w_hs) begin
                    wr_next = W_WAIT_ADDR;
                end else begin
                    wr_next = W_IDLE;
                end
            end
            W_WAIT_DATA: begin
                if (w_hs & wlast) begin
                    wr_next = W_RESP;
                end else begin
                    wr_next = W_WAIT_DATA;
                end
            end
            W_WAIT_ADDR: begin
                if (aw_hs) begin
                    wr_next = wlast_seen_r ? W_RESP : W_WAIT_DATA;
                end else begin
                    wr_next = W_WAIT_ADDR;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wr_next = W_IDLE;
                end else begin
                    wr_next = W_RESP;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Commit uses this cycle's handshake values where present, else captures
    assign wr_commit = (wr_next == W_RESP) & (wr_state != W_RESP);
    assign cur_ok    = aw_hs ? aw_legal : aw_ok_r;
    assign cur_idx   = aw_hs ? aw_off[IW+1:2] : aw_idx_r;
    assign cur_data  = w_hs ? wdata : w_data_r;
    assign cur_strb  = w_hs ? wstrb : w_strb_r;

    // Write FSM state and independent AW / W captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state     <= W_IDLE;
            aw_ok_r      <= 1'b0;
            aw_idx_r     <= '0;
            bid_r        <= '0;
            w_data_r     <= 32'h0000_0000;
            w_strb_r     <= 4'h0;
            wlast_seen_r <= 1'b0;
            bresp_r      <= 2'b00;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_ok_r  <= aw_legal;
                aw_idx_r <= aw_off[IW+1:2];
                bid_r    <= awid;
            end
            if (w_hs) begin
                w_data_r     <= wdata;
                w_strb_r     <= wstrb;
                wlast_seen_r <= wlast;
            end
            if (wr_commit) begin
                bresp_r <= cur_ok ? SCR1_AXI_RESP_OKAY : SCR1_AXI_RESP_SLVERR;
            end
        end
    end

    assign bvalid = (wr_state == W_RESP);
    assign bresp  = bresp_r;
    assign bid    = bid_r;
    assign buser  = 4'h0;

    // ---------------- read channel ----------------
    type_scr1_axi_rd_fsm_e rd_state;
    type_scr1_axi_rd_fsm_e rd_next;
    logic                  ar_hs;
    logic [3:0]            lat_cnt;
    logic [7:0]            beats;
    logic [IDW-1:0]        rid_r;
    logic [IW-1:0]         ar_idx_r;
    logic                  ar_ok_r;
    logic [1:0]            rresp_r;
    logic                  rd_sample;
    logic                  rd_ok;
    logic [IW-1:0]         rd_idx;

    assign arready = ~rst & (rd_state == R_IDLE);
    assign ar_hs   = arvalid & arready;

    // Read FSM next state
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_next = (READ_LATENCY <= 1) ? R_DATA : R_WAIT;
                end else begin
                    rd_next = R_IDLE;
                end
            end
            R_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    rd_next = R_DATA;
                end else begin
                    rd_next = R_WAIT;
                end
            end
            R_DATA: begin
                if (rready & (beats == 8'h00)) begin
                    rd_next = R_IDLE;
                end else begin
                    rd_next = R_DATA;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign rd_sample = (rd_next == R_DATA) & (rd_state != R_DATA);
    assign rd_ok     = ar_hs ? ar_legal : ar_ok_r;
    assign rd_idx    = ar_hs ? ar_off[IW+1:2] : ar_idx_r;

    // Read FSM state, latency countdown and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            lat_cnt  <= 4'd0;
            beats    <= 8'h00;
            rid_r    <= '0;
            ar_idx_r <= '0;
            ar_ok_r  <= 1'b0;
            rresp_r  <= 2'b00;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rid_r    <= arid;
                ar_idx_r <= ar_off[IW+1:2];
                ar_ok_r  <= ar_legal;
                beats    <= arlen;
                lat_cnt  <= LAT_INIT;
            end else if ((rd_state == R_WAIT) & (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end else if ((rd_state == R_DATA) & rready & (beats != 8'h00)) begin
                beats <= beats - 8'h01;
            end
            if (rd_sample) begin
                rresp_r <= rd_ok ? SCR1_AXI_RESP_OKAY : SCR1_AXI_RESP_SLVERR;
            end
        end
    end

    assign rvalid = (rd_state == R_DATA);
    assign rlast  = rvalid & (beats == 8'h00);
    assign rresp  = rresp_r;
    assign rid    = rid_r;
    assign ruser  = 4'h0;

    scr1_axi_mem_array #(
        .WORDS (WORDS),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_commit & cur_ok),
        .widx  (cur_idx),
        .wdata (cur_data),
        .wstrb (cur_strb),
        .re    (rd_sample),
        .rzero (~rd_ok),
        .ridx  (rd_idx),
        .rdata (rdata)
    );

endmodule

// File: doc/scr1_axi_mem_slave.md
Name: scr1_axi_mem_slave

Overview:
Single-port AXI4 slave memory that sits directly downstream of the core memory AXI bridge, on the instruction or data AXI port. It terminates AR/R and AW/W/B and holds a byte-addressable 32-bit-wide array. Read latency is programmable, and it returns SLVERR on illegal requests. It is used as the TCM/SRAM model in SoC integration and as the bridge's verification partner.

Parameters:
SCR1_AXI_IDWIDTH, 4, width of the AXI ID fields.
SCR1_ADDR_WIDTH, 32, AXI address width.
MEM_BASE, 32'h0000_0000, byte address of array word 0.
MEM_SIZE, 65536, array size in bytes; a power of 2, at least 4.
READ_LATENCY, 1, cycles from the AR handshake to first rvalid; range 1..15.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
awid  in  IDW  write ID
awaddr  in  AW  write address
awlen  in  8  burst length minus 1
awsize  in  3  beat size
awvalid/awready  in/out  1  AW handshake
wdata  in  32  write data
wstrb  in  4  byte strobes
wlast  in  1  last write beat
wvalid/wready  in/out  1  W handshake
bid  out  IDW  echoes the captured awid
bresp  out  2  write response
buser  out  4  tied to 0
bvalid/bready  out/in  1  B handshake
arid  in  IDW  read ID
araddr  in  AW  read address
arlen  in  8  burst length minus 1
arsize  in  3  beat size
arvalid/arready  in/out  1  AR handshake
rid  out  IDW  echoes the captured arid
rdata  out  32  read data
rresp  out  2  read response
rlast  out  1  last read beat
ruser  out  4  tied to 0
rvalid/rready  out/in  1  R handshake

Behaviour:
- Reset: clock is clk; reset rst is asynchronous, active-high.
  - While rst is asserted: awready, wready, arready, bvalid, rvalid, rlast are 0; bresp, rresp, bid, rid, rdata are 0; both FSMs go to idle; counters are 0.
  - Array contents are not reset.
  - Ready outputs are gated with ~rst. Reset mid-transaction drops the transaction silently.
- Request legality: a request is legal when all of the following hold:
  - (addr - MEM_BASE) < MEM_SIZE
  - addr[1:0] is aligned to size
  - size <= 3'b010
  - The error check is evaluated once, on the address handshake.
- Write FSM states: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP.
  - awready = W_IDLE | W_WAIT_ADDR.
  - wready = W_IDLE | W_WAIT_DATA.
  - AW and W are accepted in either order or in the same cycle, and captured independently.
  - W_IDLE: AW+W together -> W_RESP; AW only -> W_WAIT_DATA; W only -> W_WAIT_ADDR.
  - W_WAIT_DATA / W_WAIT_ADDR: leave only on the wlast beat, after AW is also held.
  - Beats before wlast are consumed and discarded. Only a single-beat (awlen==0) legal write updates the array.
  - The array write is committed on the transition into W_RESP, updating only the bytes with wstrb[i]=1.
  - If awlen!=0 or the request is illegal: no array write, bresp=2'b10.
  - W_RESP: bvalid=1 and held until bready, then -> W_IDLE. Next awready is asserted the cycle after the B handshake.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - arready = R_IDLE.
  - On the AR handshake: capture arid, the address, beat count = arlen, and the legality flag; load the latency counter with READ_LATENCY-1.
  - If READ_LATENCY==1, go to R_DATA directly; otherwise go to R_WAIT and count down to 0, then R_DATA.
  - rdata is sampled from the array on entry to R_DATA and held while rvalid & ~rready.
  - A legal arlen==0 read returns rresp=2'b00 with the full 32-bit word (no lane shifting) and rlast=1.
  - An illegal read, or one with arlen>0, returns arlen+1 beats of rdata=0 with rresp=2'b10; rlast is asserted on the final beat only.
  - Each R handshake decrements the beat count. After the last handshake -> R_IDLE.
- Concurrency:
  - The read and write FSMs run independently; there is at most one outstanding read and one outstanding write.
  - A write committed in the same cycle as a read sample to the same word: the read returns the pre-write data.
- No combinational path from any input valid to any output ready/valid.

Decomposition:
- Shared package scr1_axi_pkg holds:
  - Response constants SCR1_AXI_RESP_OKAY=2'b00 and SCR1_AXI_RESP_SLVERR=2'b10.
  - Enums type_scr1_axi_wr_fsm_e and type_scr1_axi_rd_fsm_e.
  - The legality-check function.
- One sub-module, scr1_axi_mem_array: MEM_SIZE/4 x 32 array with one byte-enabled write port and one synchronous-capture read port.

Test Plan:
- Write then read: write awaddr=MEM_BASE+8, wdata=32'hDEADBEEF, wstrb=4'hF, AW and W in the same cycle -> bvalid 1 cycle later with bresp=00 and bid=awid. Read of the same address with READ_LATENCY=3 -> rvalid 3 cycles after AR, rdata=32'hDEADBEEF, rresp=00, rlast=1.
- Write channel ordering:
  - W 2 cycles before AW, wstrb=4'b0100, wdata=32'h00AB0000 -> only byte 2 changes; readback 32'hDEABBEEF.
  - AW 2 cycles before W -> same result.
- Out-of-range read and write at MEM_BASE+MEM_SIZE -> rresp=10, rdata=0, rlast=1; bresp=10; the array is unchanged (verified by readback).
- Burst rejection: arlen=3 -> 4 R beats with rresp=10 and rlast on beat 4 only. awlen=1 with 2 W beats -> a single bresp=10 after wlast; no array write.
- Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stay stable; awready=0 and arready=0 throughout.
- Async reset asserted in W_WAIT_DATA and R_WAIT -> all valids/readies drop the same cycle. After release: awready=wready=arready=1 and no stale B/R response.
